// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: major opcodes, instruction format classes
// and the bundle the decode stage hands to execute.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } format_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        format_t         fmt;
        logic            illegal;
    } decoded_instr_t;

    // Value the output register takes out of reset.
    localparam decoded_instr_t DECODED_RESET = '{
        pc:      '0,
        opcode:  '0,
        rd:      '0,
        rs1:     '0,
        rs2:     '0,
        funct3:  '0,
        funct7:  '0,
        imm:     '0,
        fmt:     FMT_NONE,
        illegal: 1'b0
    };

endpackage

// File: rtl/immediate_generator.sv
// Combinational RV32I immediate builder: picks the immediate bits for the given
// format and sign-extends them from instr[31]; R and NONE formats yield zero.
module immediate_generator
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_instruction,
    input  format_t          i_format,
    output logic [WIDTH-1:0] o_imm
);

    logic w_sign;

    assign w_sign = i_instruction[31];

    // The opcode bits never contribute to an immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = &{1'b0, i_instruction[6:0]};

    always_comb begin
        o_imm = '0;
        case (i_format)
            FMT_I: o_imm = {{(WIDTH-12){w_sign}}, i_instruction[31:20]};
            FMT_S: o_imm = {{(WIDTH-12){w_sign}}, i_instruction[31:25],
                            i_instruction[11:7]};
            FMT_B: o_imm = {{(WIDTH-13){w_sign}}, i_instruction[31],
                            i_instruction[7], i_instruction[30:25],
                            i_instruction[11:8], 1'b0};
            FMT_U: o_imm = {i_instruction[31:12], 12'b0};
            FMT_J: o_imm = {{(WIDTH-21){w_sign}}, i_instruction[31],
                            i_instruction[19:12], i_instruction[20],
                            i_instruction[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: one output register behind a valid/ready handshake,
// splitting each accepted instruction into fields, format and immediate.
module instruction_decode
    import riscv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       instruction,
    input  logic [WIDTH-1:0]       program_counter,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_pc,
    output logic [6:0]             out_opcode,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic [WIDTH-1:0]       out_imm,
    output logic [2:0]             out_format,
    output logic                   out_illegal,
    output logic [COUNT_WIDTH-1:0] decode_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on the registered state and out_ready,
    // so the upstream valid never feeds back into ready. flush overrides any
    // transfer into this stage and invalidates whatever it holds.

    format_t                w_format;
    logic                   w_illegal;
    logic [WIDTH-1:0]       w_imm;
    logic                   w_accept;
    decoded_instr_t         w_decoded;

    decoded_instr_t         r_bundle;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_count;

    always_comb begin
        w_format = FMT_NONE;
        case (instruction[6:0])
            OPC_LUI:      w_format = FMT_U;
            OPC_AUIPC:    w_format = FMT_U;
            OPC_JAL:      w_format = FMT_J;
            OPC_JALR:     w_format = FMT_I;
            OPC_BRANCH:   w_format = FMT_B;
            OPC_LOAD:     w_format = FMT_I;
            OPC_STORE:    w_format = FMT_S;
            OPC_OP_IMM:   w_format = FMT_I;
            OPC_OP:       w_format = FMT_R;
            OPC_MISC_MEM: w_format = FMT_I;
            OPC_SYSTEM:   w_format = FMT_I;
            default:      w_format = FMT_NONE;
        endcase
    end

    // Every listed opcode ends in 2'b11, so the low-bit test is already implied;
    // it is kept explicit so the compressed-encoding case reads directly.
    assign w_illegal = (w_format == FMT_NONE) || (instruction[1:0] != 2'b11);

    immediate_generator #(
        .WIDTH(WIDTH)
    ) u_immediate_generator (
        .i_instruction(instruction),
        .i_format     (w_format),
        .o_imm        (w_imm)
    );

    always_comb begin
        w_decoded         = DECODED_RESET;
        w_decoded.pc      = program_counter;
        w_decoded.opcode  = instruction[6:0];
        w_decoded.rd      = instruction[11:7];
        w_decoded.rs1     = instruction[19:15];
        w_decoded.rs2     = instruction[24:20];
        w_decoded.funct3  = instruction[14:12];
        w_decoded.funct7  = instruction[31:25];
        w_decoded.imm     = w_imm;
        w_decoded.fmt     = w_format;
        w_decoded.illegal = w_illegal;
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_bundle <= DECODED_RESET;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_count  <= r_count + COUNT_WIDTH'(1);
            r_bundle <= w_decoded;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_bundle.pc;
    assign out_opcode   = r_bundle.opcode;
    assign out_rd       = r_bundle.rd;
    assign out_rs1      = r_bundle.rs1;
    assign out_rs2      = r_bundle.rs2;
    assign out_funct3   = r_bundle.funct3;
    assign out_funct7   = r_bundle.funct7;
    assign out_imm      = r_bundle.imm;
    assign out_format   = r_bundle.fmt;
    assign out_illegal  = r_bundle.illegal;
    assign decode_count = r_count;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus randomized traffic
// against a field-level RV32I decode model and an expected-bundle queue.
module tb_instruction_decode;
    import riscv_pkg::*;

    localparam int BW = 100;
    localparam logic [BW-1:0] RST_BUNDLE = {96'b0, 3'd6, 1'b0};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_format;
    logic        out_illegal;
    logic [31:0] decode_count;

    int total = 0;
    int bad   = 0;

    logic          m_valid;
    logic [31:0]   m_count;
    logic [BW-1:0] m_data;
    logic [BW-1:0] exp_q[$];

    logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    wire [BW-1:0] obs = {out_pc, out_opcode, out_rd, out_rs1, out_rs2,
                         out_funct3, out_funct7, out_imm, out_format, out_illegal};

    instruction_decode #(
        .WIDTH(32),
        .COUNT_WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .program_counter(program_counter),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_funct3     (out_funct3),
        .out_funct7     (out_funct7),
        .out_imm        (out_imm),
        .out_format     (out_format),
        .out_illegal    (out_illegal),
        .decode_count   (decode_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode built from the ISA field definitions with integer math.
    function automatic logic [BW-1:0] ref_decode(input logic [31:0] ins,
                                                 input logic [31:0] pc);
        logic [2:0]  fmt;
        logic        ill;
        int          si;
        int          v;
        si  = int'($signed(ins));
        ill = 1'b0;
        v   = 0;
        case (ins[6:0])
            7'h37, 7'h17:                      fmt = FMT_U;
            7'h6F:                             fmt = FMT_J;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: fmt = FMT_I;
            7'h63:                             fmt = FMT_B;
            7'h23:                             fmt = FMT_S;
            7'h33:                             fmt = FMT_R;
            default: begin fmt = FMT_NONE; ill = 1'b1; end
        endcase
        if (ins[1:0] != 2'b11) ill = 1'b1;
        case (fmt)
            FMT_I: v = si >>> 20;
            FMT_S: v = (si >>> 25) * 32 + int'(ins[11:7]);
            FMT_B: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                       + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            FMT_U: v = int'(ins & 32'hFFFF_F000);
            FMT_J: v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                       + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return {pc, ins[6:0], ins[11:7], ins[19:15], ins[24:20], ins[14:12],
                ins[31:25], v[31:0], fmt, ill};
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid        = v;
        instruction     = ins;
        program_counter = pc;
        out_ready       = ordy;
        flush           = fl;
    endtask

    task automatic tick();
        logic acc;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_data  = ref_decode(instruction, program_counter);
            m_count = m_count + 32'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_count = 32'd0;
        m_data  = RST_BUNDLE;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (decode_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", decode_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (out_format !== 3'd6) begin bad++; $display("FAIL reset_format: got %0d want 6", out_format); end
        total++; if (obs !== RST_BUNDLE) begin bad++; $display("FAIL reset_fields: got %h want %h", obs, RST_BUNDLE); end
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
        total++; if (out_rd !== 5'd1) begin bad++; $display("FAIL addi_rd: got %0d want 1", out_rd); end
        total++; if (out_rs1 !== 5'd0) begin bad++; $display("FAIL addi_rs1: got %0d want 0", out_rs1); end
        total++; if (out_funct3 !== 3'd0) begin bad++; $display("FAIL addi_funct3: got %0d want 0", out_funct3); end
        total++; if (out_imm !== 32'h5) begin bad++; $display("FAIL addi_imm: got %h want 00000005", out_imm); end
        total++; if (out_format !== 3'd1) begin bad++; $display("FAIL addi_format: got %0d want 1", out_format); end
        total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal: got %0b want 0", out_illegal); end
        total++; if (decode_count !== 32'd1) begin bad++; $display("FAIL addi_count: got %0d want 1", decode_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain: got %0b want 0", out_valid); end
        total++; if (obs !== ref_decode(32'h0050_0093, 32'h0)) begin bad++; $display("FAIL addi_hold: got %h want %h", obs, ref_decode(32'h0050_0093, 32'h0)); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'hFE00_0EE3, 32'h10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h0080_00EF, 32'h14, 1'b1, 1'b0);
        #1;
        total++; if (out_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq_imm: got %h want fffffffc", out_imm); end
        total++; if (out_format !== 3'd3) begin bad++; $display("FAIL beq_format: got %0d want 3", out_format); end
        total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL beq_pc: got %h want 00000010", out_pc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL jal_valid: got %0b want 1", out_valid); end
        total++; if (out_imm !== 32'h8) begin bad++; $display("FAIL jal_imm: got %h want 00000008", out_imm); end
        total++; if (out_format !== 3'd5) begin bad++; $display("FAIL jal_format: got %0d want 5", out_format); end
        total++; if (out_rd !== 5'd1) begin bad++; $display("FAIL jal_rd: got %0d want 1", out_rd); end
        total++; if (decode_count !== 32'd3) begin bad++; $display("FAIL jal_count: got %0d want 3", decode_count); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        drive(1'b1, 32'h00A0_0113, 32'h20, 1'b1, 1'b0);
        tick();
        c0 = m_count;
        drive(1'b1, 32'h1234_50B7, 32'h24, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
            tick();
            total++; if ({out_valid, obs} !== {1'b1, ref_decode(32'h00A0_0113, 32'h20)}) begin bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {out_valid, obs}, {1'b1, ref_decode(32'h00A0_0113, 32'h20)}); end
            total++; if (decode_count !== c0) begin bad++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, decode_count, c0); end
        end
        drive(1'b1, 32'h1234_50B7, 32'h24, 1'b1, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (out_imm !== 32'h1234_5000) begin bad++; $display("FAIL lui_imm: got %h want 12345000", out_imm); end
        total++; if (obs !== ref_decode(32'h1234_50B7, 32'h24)) begin bad++; $display("FAIL release_fields: got %h want %h", obs, ref_decode(32'h1234_50B7, 32'h24)); end
        total++; if (decode_count !== c0 + 32'd1) begin bad++; $display("FAIL release_count: got %0d want %0d", decode_count, c0 + 32'd1); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] c0;
        drive(1'b1, 32'h0000_A103, 32'h30, 1'b1, 1'b0);
        tick();
        c0 = m_count;
        drive(1'b1, 32'h00C5_8533, 32'h34, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        total++; if (decode_count !== c0) begin bad++; $display("FAIL flush_count: got %0d want %0d", decode_count, c0); end
        repeat (3) tick();
        total++; if ({out_valid, out_pc} !== {1'b0, 32'h30}) begin bad++; $display("FAIL flush_dropped: got %h want %h", {out_valid, out_pc}, {1'b0, 32'h30}); end
    endtask

    task automatic test_illegal_async_reset();
        drive(1'b1, 32'h0, 32'h40, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid: got %0b want 1", out_valid); end
        total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag: got %0b want 1", out_illegal); end
        total++; if (out_format !== 3'd6) begin bad++; $display("FAIL illegal_format: got %0d want 6", out_format); end
        total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL illegal_imm: got %h want 00000000", out_imm); end
        tick();
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %0b want 0", out_valid); end
        total++; if (decode_count !== 32'd0) begin bad++; $display("FAIL async_rst_count: got %0d want 0", decode_count); end
        total++; if (obs !== RST_BUNDLE) begin bad++; $display("FAIL async_rst_fields: got %h want %h", obs, RST_BUNDLE); end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] ins;
        logic        v;
        logic        ordy;
        logic        fl;
        logic [BW-1:0] e;
        int sel;
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            sel = $urandom_range(0, 15);
            if (sel < 11)      ins = {r[31:7], opc_tab[sel]};
            else if (sel < 14) ins = r;
            else               ins = r & 32'hFFFF_FFFC;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 9) == 0);
            drive(v, ins, $urandom(), ordy, fl);
            #1;
            total++; if (in_ready !== (!m_valid || ordy)) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", n, in_ready, !m_valid || ordy); end
            if (m_valid && ordy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_sb_empty[%0d]: got valid bundle want none", n);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin bad++; $display("FAIL rnd_sb[%0d]: got %h want %h", n, obs, e); end
                end
            end else if (m_valid && fl && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (v && (!m_valid || ordy) && !fl) exp_q.push_back(ref_decode(ins, program_counter));
            tick();
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, out_valid, m_valid); end
            total++; if (decode_count !== m_count) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, decode_count, m_count); end
            total++; if (obs !== m_data) begin bad++; $display("FAIL rnd_fields[%0d]: got %h want %h", n, obs, m_data); end
        end
        total++; if (exp_q.size() != (m_valid ? 1 : 0)) begin bad++; $display("FAIL rnd_sb_left: got %0d want %0d", exp_q.size(), m_valid ? 1 : 0); end
    endtask

    initial begin
        rst = 1'b0;
        m_valid = 1'b0;
        m_count = 32'd0;
        m_data  = RST_BUNDLE;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction fetch.
- Registers each fetched RV32I instruction with its program counter and splits it into register indices, funct fields, format class and sign-extended immediate.
- Flags unsupported encodings as illegal.
- Provides a valid/ready handshake with stall and flush, so execute can back-pressure and branch resolution can squash the stage.

Parameters:
- WIDTH, 32, datapath / program-counter width; must be 32 for RV32I.
- COUNT_WIDTH, 32, width of the accepted-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  fetch presents a valid instruction
- in_ready  output  1  stage can accept this cycle
- instruction  input  WIDTH  raw instruction word from fetch
- program_counter  input  WIDTH  PC of instruction
- flush  input  1  squash held and incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts bundle
- out_pc  output  WIDTH  registered PC
- out_opcode  output  7  instr[6:0]
- out_rd  output  5  instr[11:7]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_imm  output  WIDTH  sign-extended immediate
- out_format  output  3  format_t: R, I, S, B, U, J, NONE
- out_illegal  output  1  unsupported opcode or instr[1:0] != 2'b11
- decode_count  output  COUNT_WIDTH  instructions accepted since reset

Behaviour:
- Single output register stage; latency 1 cycle from accept to out_valid.
- Reset (async assert; deassertion is assumed synchronised externally):
  - out_valid=0, decode_count=0.
  - All out_* data fields = 0, out_format=NONE, out_illegal=0.
- in_ready = !out_valid || out_ready (combinational). No bubble under continuous flow.
- Accept = in_valid && in_ready && !flush.
  - On accept, all fields load from the decode of instruction.
  - out_valid<=1 and decode_count increments, wrapping modulo 2^COUNT_WIDTH.
- Handshake completes without a new accept (out_valid && out_ready, no accept): out_valid<=0; data fields hold their last value.
- Stall (out_valid && !out_ready): all outputs hold and are stable; in_ready=0.
- Flush has priority over everything: out_valid<=0, incoming instruction dropped, decode_count unchanged. A flush with in_valid=1 does not count.
- Opcode map (anything else -> NONE, illegal=1, imm=0):
  - 0110111 LUI: U
  - 0010111 AUIPC: U
  - 1101111 JAL: J
  - 1100111 JALR: I
  - 1100011 BRANCH: B
  - 0000011 LOAD: I
  - 0100011 STORE: S
  - 0010011 OP-IMM: I
  - 0110011 OP: R
  - 0001111 MISC-MEM: I
  - 1110011 SYSTEM: I
- Illegal instructions still propagate with out_valid=1 so execute can trap.
- Immediates, always sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: imm=0
- Raw field outputs (rd/rs1/rs2/funct3/funct7) are always sliced from the word, regardless of format.
- Reset asserted mid-stall clears out_valid immediately (asynchronously). Any held instruction is lost.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OPC_LUI ... OPC_SYSTEM).
  - typedef enum logic [2:0] format_t {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE}.
  - typedef struct decoded_instr_t bundling the out_* fields.
- Sub-module immediate_generator, purely combinational: instruction and format in, imm out.
- Opcode-to-format lookup and the handshake register live in the top module.

Test Plan:
- Reset, then idle with in_valid=0 -> out_valid=0, decode_count=0, in_ready=1, out_format=NONE.
- Send 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, funct3=0, imm=0x00000005, format=I, illegal=0, count=1.
- Send 0xFE000EE3 (beq x0,x0,-4) at PC 0x10 -> imm=0xFFFFFFFC, format=B, out_pc=0x10. Then send 0x008000EF (jal x1,8) -> imm=0x00000008, format=J, rd=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 and a new word -> in_ready=0 and outputs unchanged. Release -> new word appears next cycle, count incremented once per word.
- Assert flush together with in_valid=1 while out_valid=1 -> next cycle out_valid=0, count unchanged, dropped word never appears.
- Send 0x00000000 -> out_valid=1, illegal=1, format=NONE, imm=0. Assert rst asynchronously mid-stall -> out_valid=0 before the next clock edge.
